alu_share_arbiter: RTL and testbench

- Shares the single 8-bit adder ALU (readdata1 + (alusrc ? sign_extended : readdata2)) between two requesters, port 0 = main datapath and port 1 = address/auxiliary unit.
- Round-robin arbitration, operand latching, result capture and one-cycle done pulse per requester.
- Sits between the requesters and the ALU instance; the ALU itself stays purely combinational and external.

---
 rtl/alu_share_arbiter.sv | 108 ++++++++++
 tb/tb_alu_share_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational adder ALU between two requesters.
// Operands are latched on grant; the result is captured after one EXEC cycle and flagged by a done pulse.
module alu_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] imm0,
    input  logic             src0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] imm1,
    input  logic             src1,
    output logic [WIDTH-1:0] alu_readdata1,
    output logic [WIDTH-1:0] alu_readdata2,
    output logic [WIDTH-1:0] alu_sign_extended,
    output logic             alu_alusrc,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] result,
    output logic             done0,
    output logic             done1,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             owner;
    logic             grant_valid;
    logic             grant_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_imm;
    logic             op_src;
    logic [WIDTH-1:0] result_q;

    // A tie goes to whichever requester was not served last.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_imm     <= '0;
            op_src     <= 1'b0;
            result_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner  <= grant_id;
                        op_a   <= grant_id ? a1   : a0;
                        op_b   <= grant_id ? b1   : b0;
                        op_imm <= grant_id ? imm1 : imm0;
                        op_src <= grant_id ? src1 : src0;
                    end
                end
                EXEC:    result_q   <= alu_out;
                DONE:    last_grant <= owner;
                default: ;
            endcase
        end
    end

    // The ALU only ever sees registered operands, never the live requester inputs.
    assign alu_readdata1     = op_a;
    assign alu_readdata2     = op_b;
    assign alu_sign_extended = op_imm;
    assign alu_alusrc        = op_src;

    assign result = result_q;
    assign done0  = (state == DONE) && !owner;
    assign done1  = (state == DONE) &&  owner;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed operations push hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_share_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, req1, src0, src1;
    logic [WIDTH-1:0] a0, b0, imm0, a1, b1, imm1;
    logic [WIDTH-1:0] alu_readdata1, alu_readdata2, alu_sign_extended, alu_out, result;
    logic             alu_alusrc, done0, done1, busy;

    typedef struct packed {
        logic             port;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // External combinational ALU.
    assign alu_out = alu_readdata1 + (alu_alusrc ? alu_sign_extended : alu_readdata2);

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .imm0(imm0), .src0(src0),
        .req1(req1), .a1(a1), .b1(b1), .imm1(imm1), .src1(src1),
        .alu_readdata1(alu_readdata1), .alu_readdata2(alu_readdata2),
        .alu_sign_extended(alu_sign_extended), .alu_alusrc(alu_alusrc),
        .alu_out(alu_out), .result(result),
        .done0(done0), .done1(done1), .busy(busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done0 || done1) begin
            check("done_exclusive", int'(done0 & done1), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done0=%0b done1=%0b with empty scoreboard", done0, done1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_port", int'(done1), int'(e.port));
                check("result", int'(result), int'(e.res));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the given port's done, then drops that req inside the done cycle.
    task automatic wait_done(input logic port, output int lat);
        bit found = 0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if ((port ? done1 : done0) === 1'b1) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: port %0d saw no done within 20 cycles", port);
        end
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        req0 = 0; a0 = '0; b0 = '0; imm0 = '0; src0 = 0;
        req1 = 0; a1 = '0; b1 = '0; imm1 = '0; src1 = 0;
        repeat (3) step();
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(result), 0);
        check("rst_done", int'({done0, done1}), 0);
        check("rst_alu", int'({alu_readdata1, alu_readdata2, alu_sign_extended, alu_alusrc}), 0);
        reset = 1'b0;

        // Tie straight after reset: 0 first, then alternating for 4 operations.
        a0 = 8'h21; b0 = 8'h13; src0 = 0;
        a1 = 8'h40; b1 = 8'h99; imm1 = 8'h05; src1 = 1;
        req0 = 1; req1 = 1;
        sb.push_back('{1'b0, 8'h34});
        sb.push_back('{1'b1, 8'h45});
        sb.push_back('{1'b0, 8'h34});
        sb.push_back('{1'b1, 8'h45});
        for (int n = 0; n < 4; n++) begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done0 || done1) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL tie_timeout: operation %0d never completed", n);
            end
        end
        req0 = 0; req1 = 0;
        step();
        check("tie_idle", int'(busy), 0);

        // Single op on port 0 with register operand.
        a0 = 8'h12; b0 = 8'h34; imm0 = 8'hAA; src0 = 0;
        req0 = 1;
        sb.push_back('{1'b0, 8'h46});
        step();
        check("p0_exec_busy", int'(busy), 1);
        check("p0_exec_rd1", int'(alu_readdata1), 8'h12);
        check("p0_exec_rd2", int'(alu_readdata2), 8'h34);
        check("p0_exec_src", int'(alu_alusrc), 0);
        wait_done(1'b0, lat);
        check("p0_latency", lat, 2);
        step();

        // Immediate path on port 1; done must be a single-cycle pulse.
        a1 = 8'h10; b1 = 8'h77; imm1 = 8'hFE; src1 = 1;
        req1 = 1;
        sb.push_back('{1'b1, 8'h0E});
        step();
        check("p1_exec_src", int'(alu_alusrc), 1);
        check("p1_exec_imm", int'(alu_sign_extended), 8'hFE);
        wait_done(1'b1, lat);
        @(negedge clk);
        check("p1_done_pulse", int'(done1), 0);
        check("p1_result_hold", int'(result), 8'h0E);
        step();

        // Operand change after grant plus carry wrap.
        a0 = 8'hFF; b0 = 8'h01; src0 = 0;
        req0 = 1;
        sb.push_back('{1'b0, 8'h00});
        step();
        a0 = 8'h55; b0 = 8'h22;
        #1;
        check("latched_rd1", int'(alu_readdata1), 8'hFF);
        wait_done(1'b0, lat);
        step();

        // Reset during EXEC aborts; held req1 is served afterwards.
        a0 = 8'h0A; b0 = 8'h0B; src0 = 0;
        a1 = 8'h30; b1 = 8'h0C; src1 = 0;
        req0 = 1;
        step();
        check("abort_exec_busy", int'(busy), 1);
        req1 = 1;
        reset = 1;
        req0 = 0;
        step();
        check("abort_busy", int'(busy), 0);
        check("abort_result", int'(result), 0);
        check("abort_alu", int'({alu_readdata1, alu_readdata2, alu_sign_extended, alu_alusrc}), 0);
        reset = 0;
        sb.push_back('{1'b1, 8'h3C});
        wait_done(1'b1, lat);
        step();

        // Late request from port 1 during port 0's EXEC.
        a0 = 8'h03; b0 = 8'h04; src0 = 0;
        a1 = 8'h20; b1 = 8'h05; src1 = 0;
        req0 = 1;
        sb.push_back('{1'b0, 8'h07});
        sb.push_back('{1'b1, 8'h25});
        step();
        req1 = 1;
        wait_done(1'b0, lat);
        step();
        check("gap_busy_low", int'(busy), 0);
        step();
        check("gap_busy_high", int'(busy), 1);
        check("late_rd1", int'(alu_readdata1), 8'h20);
        wait_done(1'b1, lat);
        repeat (3) step();

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
